// File: rtl/axi_lite_manager_if.sv
// axi_lite_manager_if: AXI4 bus between a single-outstanding manager and a subordinate.
interface axi_lite_manager_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    localparam int NB = DATA_W / 8;
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [NB-1:0]     WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_lite_manager.sv
// axi_lite_manager: single-outstanding command/response to AXI4-Lite write/read converter.
module axi_lite_manager #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    axi_lite_manager_if.master  bus
);
    localparam int NB = DATA_W / 8;
    localparam int LSB = $clog2(NB);
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                misaligned;

    assign misaligned = cmd_addr[LSB-1:0] != '0;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        id_d      = id_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            IDLE: if (cmd_valid) begin
                write_d   = cmd_write;
                id_d      = cmd_id;
                addr_d    = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                rdata_d   = '0;
                resp_d    = misaligned ? SLVERR : 2'b00;
                state_d   = misaligned ? RSP : (cmd_write ? WR : RD_A);
            end
            // AW and W complete independently; the done flags keep each VALID low once accepted
            WR: begin
                aw_done_d = aw_done_q | bus.AWREADY;
                w_done_d  = w_done_q | bus.WREADY;
                if (aw_done_d && w_done_d) state_d = WR_B;
            end
            WR_B: if (bus.BVALID) begin
                resp_d  = (bus.BID != id_q) ? SLVERR : bus.BRESP;
                state_d = RSP;
            end
            RD_A: if (bus.ARREADY) state_d = RD_R;
            RD_R: if (bus.RVALID) begin
                rdata_d = bus.RDATA;
                resp_d  = (bus.RID != id_q) ? SLVERR : bus.RRESP;
                state_d = RSP;
            end
            RSP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE) && !ARESET;
    assign rsp_valid   = state_q == RSP;
    assign rsp_write   = write_q;
    assign rsp_id      = id_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;

    assign bus.AWID    = id_q;
    assign bus.AWADDR  = addr_q;
    assign bus.AWLEN   = 8'd0;
    assign bus.AWSIZE  = 3'(LSB);
    assign bus.AWBURST = 2'b01;
    assign bus.AWVALID = (state_q == WR) && !aw_done_q;
    assign bus.WDATA   = wdata_q;
    assign bus.WSTRB   = wstrb_q;
    assign bus.WLAST   = 1'b1;
    assign bus.WVALID  = (state_q == WR) && !w_done_q;
    assign bus.BREADY  = state_q == WR_B;
    assign bus.ARID    = id_q;
    assign bus.ARADDR  = addr_q;
    assign bus.ARLEN   = 8'd0;
    assign bus.ARSIZE  = 3'(LSB);
    assign bus.ARBURST = 2'b01;
    assign bus.ARVALID = state_q == RD_A;
    assign bus.RREADY  = state_q == RD_R;
endmodule

// File: doc/axi_lite_manager.md
# axi_lite_manager

Single-outstanding AXI4-Lite manager that converts a simple command/response handshake into AXI write (AW/W/B) or read (AR/R) transactions. It sits directly upstream of `axi_subordinate` and drives the manager side of `axi4_if`. Test sequences and future on-chip requesters use it instead of hand-driven bus tasks.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data width; bytes per beat `NB = DATA_W/8`
- `ID_W`, 4, AXI ID width
- `ACLK`  in  1  clock; all logic on rising edge
- `ARESET`  in  1  synchronous, active-high reset
- `cmd_valid`/`cmd_ready`  in/out  1  command handshake
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_id`  in  ID_W  transaction ID
- `cmd_addr`  in  ADDR_W  byte address
- `cmd_wdata`  in  DATA_W  write data
- `cmd_wstrb`  in  NB  write byte strobes
- `rsp_valid`/`rsp_ready`  out/in  1  response handshake
- `rsp_write`  out  1  response belongs to a write
- `rsp_id`  out  ID_W  ID of the completed command
- `rsp_rdata`  out  DATA_W  read data; 0 for writes
- `rsp_resp`  out  2  OKAY=00, SLVERR=10, DECERR=11
- `AWID`/`AWADDR`/`AWVALID`/`AWREADY`  out/out/out/in  ID_W/ADDR_W/1/1  write address channel
- `WDATA`/`WSTRB`/`WVALID`/`WREADY`  out/out/out/in  DATA_W/NB/1/1  write data channel
- `BID`/`BRESP`/`BVALID`/`BREADY`  in/in/in/out  ID_W/2/1/1  write response channel
- `ARID`/`ARADDR`/`ARVALID`/`ARREADY`  out/out/out/in  ID_W/ADDR_W/1/1  read address channel
- `RID`/`RDATA`/`RRESP`/`RVALID`/`RREADY`  in/in/in/in/out  ID_W/DATA_W/2/1/1  read data channel
- AXI4 burst fields are tied off: `AWLEN`/`ARLEN`=0, `AWSIZE`/`ARSIZE`=log2(NB), `AWBURST`/`ARBURST`=INCR, `WLAST`=1. `RLAST` is ignored.

## Operation
- States: IDLE, WR (AW+W), WR_B, RD_A, RD_R, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, capture all `cmd_*` fields into registers. Next state:
  - Misaligned address (`cmd_addr % NB != 0`): RSP with `rsp_resp`=SLVERR. No AXI traffic is issued.
  - Aligned write: WR.
  - Aligned read: RD_A.
- WR: `AWVALID` and `WVALID` are asserted together. Each drops independently once its own handshake completes (`aw_done`/`w_done` flags). When both are done, go to WR_B. AW and W may complete in the same cycle or in either order.
- WR_B: `BREADY`=1. On `BVALID`, capture `BRESP` and go to RSP.
- RD_A: `ARVALID`=1 until `ARREADY`, then go to RD_R.
- RD_R: `RREADY`=1. On `RVALID`, capture `RDATA`/`RRESP` and go to RSP.
- ID check: if `BID`/`RID` differs from the issued ID, force `rsp_resp`=SLVERR. Data is still captured.
- RSP: `rsp_valid`=1 with all response fields held stable until `rsp_ready`, then go to IDLE.
- Address, data, strobe and ID outputs stay stable while the corresponding VALID is high.
- VALIDs never depend combinationally on READYs.
- Only one transaction is outstanding at a time. `cmd_ready`=0 outside IDLE.

## Timing
- Reset (`ARESET`=1 at a rising edge):
  - State goes to IDLE.
  - All VALID and READY outputs, `rsp_*` outputs and the address/data registers go to 0.
  - `cmd_ready` reads 0 while `ARESET` is high and 1 in the first cycle after.
- Reset mid-transaction aborts it. There is no response and the VALIDs drop at that edge.
- Command accepted at edge N: `AWVALID`/`WVALID` (or `ARVALID`) go high after edge N.
- With zero-wait READYs, a write takes:
  - AW/W handshake at edge N+1
  - `BREADY` high from N+1; `BVALID` accepted at the earliest edge after that
  - `rsp_valid` high the cycle after B is accepted
- Misaligned command accepted at edge N: `rsp_valid` is high after edge N.
- Response accepted at edge M: `cmd_ready`=1 after edge M. The next command can be accepted at edge M+1.
- `BREADY` and `RREADY` are high only in WR_B and RD_R respectively.

## Test plan
- Write 0x1111_2222_3333_4444 to 0x20 with ID 1 and `wstrb`=0xFF, then read 0x20 -> write rsp OKAY/ID 1; read rsp OKAY, rdata 0x1111_2222_3333_4444.
- Write to 0x2000 (outside the 4 KB subordinate) -> `rsp_resp`=11 (DECERR). A read of 0x2000 -> DECERR.
- Subordinate model delays `WREADY` 3 cycles after `AWREADY`, then the reverse -> `AWVALID` drops after its handshake, `WVALID` persists, exactly one AW and one W beat, rsp OKAY.
- Command to 0x24 (misaligned) -> `AWVALID`/`ARVALID` never rise; `rsp_valid` the cycle after accept with `rsp_resp`=10.
- `rsp_ready` held low 5 cycles after a read of 0x0FF0 -> `rsp_valid` and `rsp_rdata` stable throughout, `cmd_ready`=0 until accept.
- Assert `ARESET` for one cycle while in WR_B -> all VALID/READY outputs 0 and state IDLE; a following write/read of 0x50 completes OKAY.
